// File: rtl/counter_regs_pkg.sv
// Shared constants and types for the Counter control register slave.
package counter_regs_pkg;

    // Word offsets, decoded from addr[3:2]
    localparam logic [1:0] CTRL_OFS    = 2'd0;
    localparam logic [1:0] COUNT_OFS   = 2'd1;
    localparam logic [1:0] SCRATCH_OFS = 2'd2;
    localparam logic [1:0] ID_OFS      = 2'd3;

    localparam logic [31:0] ID_BASE = 32'h434E_5400;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    // Byte-lane merge of a write beat into an existing register value
    function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                                input logic [31:0] data,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = data[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/counter_axil_regs.sv
// AXI4-Lite register slave in front of the Counter block: CTRL drives the
// counter's user_reset (HOLD level plus a one-cycle PULSE), COUNT reads back
// the counter value, SCRATCH is a plain RW word and ID identifies the block.
//
// state  | meaning
// -------+--------------------------------------------------------------
// W_IDLE | collecting AW and W beats (either order); commit when both held
// W_RESP | bvalid high, waiting for bready
// R_IDLE | arready high, waiting for an AR beat
// R_DATA | rvalid high with registered rdata/rresp, waiting for rready
module counter_axil_regs
    import counter_regs_pkg::*;
#(
    parameter int COUNTER_WIDTH = 4,
    parameter int ADDR_WIDTH    = 4
) (
    input  logic                     clk,
    input  logic                     areset,
    input  logic [ADDR_WIDTH-1:0]    s_axil_awaddr,
    input  logic                     s_axil_awvalid,
    output logic                     s_axil_awready,
    input  logic [31:0]              s_axil_wdata,
    input  logic [3:0]               s_axil_wstrb,
    input  logic                     s_axil_wvalid,
    output logic                     s_axil_wready,
    output logic [1:0]               s_axil_bresp,
    output logic                     s_axil_bvalid,
    input  logic                     s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]    s_axil_araddr,
    input  logic                     s_axil_arvalid,
    output logic                     s_axil_arready,
    output logic [31:0]              s_axil_rdata,
    output logic [1:0]               s_axil_rresp,
    output logic                     s_axil_rvalid,
    input  logic                     s_axil_rready,
    input  logic [COUNTER_WIDTH-1:0] counter_datain,
    output logic                     user_reset
);

    wr_state_e             wr_state_q, wr_state_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  hold_q, hold_d;
    logic                  pulse_q, pulse_d;
    logic [31:0]           scratch_q, scratch_d;

    rd_state_e             rd_state_q, rd_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic                  aw_fire;
    logic                  w_fire;
    logic                  ar_fire;

    // Byte-lane bits of the addresses carry no decode information
    logic                  unused_addr_lsbs;

    // Only the low 16 bytes of the address space are mapped
    function automatic logic addr_mapped(input logic [ADDR_WIDTH-1:0] a);
        return (a >> 4) == '0;
    endfunction

    assign aw_fire = s_axil_awvalid & awready_q;
    assign w_fire  = s_axil_wvalid & wready_q;
    assign ar_fire = s_axil_arvalid & arready_q;

    assign unused_addr_lsbs = ^{awaddr_q[1:0], s_axil_araddr[1:0]};

    // Write FSM: latch AW/W independently, commit once both are held
    always_comb begin
        wr_state_d = wr_state_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        hold_d     = hold_q;
        scratch_d  = scratch_q;
        pulse_d    = 1'b0;

        case (wr_state_q)
            W_IDLE: begin
                if (aw_fire) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = s_axil_awaddr;
                end
                if (w_fire) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_axil_wdata;
                    wstrb_d  = s_axil_wstrb;
                end
                // Also raises the readies on the first edge after reset
                awready_d = ~aw_held_d;
                wready_d  = ~w_held_d;

                if (aw_held_d && w_held_d) begin
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    awready_d  = 1'b0;
                    wready_d   = 1'b0;
                    bvalid_d   = 1'b1;
                    wr_state_d = W_RESP;
                    bresp_d    = RESP_SLVERR;
                    if (addr_mapped(awaddr_d)) begin
                        case (awaddr_d[3:2])
                            CTRL_OFS: begin
                                bresp_d = RESP_OKAY;
                                if (wstrb_d[0]) begin
                                    hold_d  = wdata_d[0];
                                    pulse_d = wdata_d[1];
                                end
                            end
                            SCRATCH_OFS: begin
                                bresp_d   = RESP_OKAY;
                                scratch_d = apply_wstrb(scratch_q, wdata_d, wstrb_d);
                            end
                            default: bresp_d = RESP_SLVERR;
                        endcase
                    end
                end
            end
            W_RESP: begin
                if (s_axil_bready) begin
                    bvalid_d   = 1'b0;
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Write-side state and register storage
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            wr_state_q <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            hold_q     <= 1'b0;
            pulse_q    <= 1'b0;
            scratch_q  <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            hold_q     <= hold_d;
            pulse_q    <= pulse_d;
            scratch_q  <= scratch_d;
        end
    end

    // Read FSM: register data/response on the AR handshake; CTRL reads see
    // the pre-commit value because hold_q only changes on that same edge
    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;

        case (rd_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_fire) begin
                    arready_d  = 1'b0;
                    rvalid_d   = 1'b1;
                    rd_state_d = R_DATA;
                    rdata_d    = '0;
                    rresp_d    = RESP_SLVERR;
                    if (addr_mapped(s_axil_araddr)) begin
                        rresp_d = RESP_OKAY;
                        case (s_axil_araddr[3:2])
                            CTRL_OFS:    rdata_d = {31'b0, hold_q};
                            COUNT_OFS:   rdata_d = 32'(counter_datain);
                            SCRATCH_OFS: rdata_d = scratch_q;
                            ID_OFS:      rdata_d = ID_BASE | 32'(COUNTER_WIDTH);
                            default:     rdata_d = '0;
                        endcase
                    end
                end
            end
            R_DATA: begin
                if (s_axil_rready) begin
                    rvalid_d   = 1'b0;
                    arready_d  = 1'b1;
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Read-side state
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign s_axil_awready = awready_q;
    assign s_axil_wready  = wready_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = arready_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;
    assign user_reset     = hold_q | pulse_q;

endmodule

// File: tb/tb_counter_axil_regs.sv
// Bench for counter_axil_regs with a 4-bit free-running Counter attached.
module tb_counter_axil_regs;

    logic        clk = 1'b0;
    logic        areset = 1'b0;
    logic [4:0]  s_axil_awaddr = '0;
    logic        s_axil_awvalid = 1'b0;
    logic        s_axil_awready;
    logic [31:0] s_axil_wdata = '0;
    logic [3:0]  s_axil_wstrb = '0;
    logic        s_axil_wvalid = 1'b0;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready = 1'b0;
    logic [4:0]  s_axil_araddr = '0;
    logic        s_axil_arvalid = 1'b0;
    logic        s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid;
    logic        s_axil_rready = 1'b0;
    logic [3:0]  cnt;
    logic        user_reset;

    int n_checks = 0;
    int n_fail = 0;
    int ecnt = 0;
    int ur_cycles = 0;
    int ur_rise_edge = -1;
    int b_rises = 0;
    logic ur_prev = 1'b0;
    logic bv_prev = 1'b0;

    // reference model state
    logic        hold_m = 1'b0;
    logic [31:0] scratch_m = '0;
    int          last_clr = 0;
    int          last_commit = -1;

    counter_axil_regs #(.COUNTER_WIDTH(4), .ADDR_WIDTH(5)) dut (
        .clk(clk), .areset(areset),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
        .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
        .s_axil_rready(s_axil_rready),
        .counter_datain(cnt), .user_reset(user_reset)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    // The Counter: +1 per cycle, synchronous clear on user_reset
    always @(posedge clk or negedge areset) begin
        if (!areset) cnt <= '0;
        else if (user_reset) cnt <= '0;
        else cnt <= cnt + 4'd1;
    end

    always @(negedge clk) begin
        if (user_reset) begin
            ur_cycles = ur_cycles + 1;
            if (!ur_prev) ur_rise_edge = ecnt;
        end
        ur_prev = user_reset;
        if (s_axil_bvalid && !bv_prev) b_rises = b_rises + 1;
        bv_prev = s_axil_bvalid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_wr_resp(input logic [4:0] a);
        if (a[4]) return 2'b10;
        return (a[3:2] == 2'd0 || a[3:2] == 2'd2) ? 2'b00 : 2'b10;
    endfunction

    // Counter value sampled on edge hs: what it held after edge hs-1
    function automatic logic [31:0] exp_rd_data(input logic [4:0] a, input int hs);
        if (a[4]) return 32'h0;
        case (a[3:2])
            2'd0:    return {31'b0, hold_m};
            2'd1:    return hold_m ? 32'h0 : 32'((hs - 1 - last_clr) & 15);
            2'd2:    return scratch_m;
            default: return 32'h434E_5404;
        endcase
    endfunction

    task automatic model_commit(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, input int ce);
        last_commit = ce;
        if (!a[4] && a[3:2] == 2'd0 && s[0]) begin
            if (d[0]) hold_m = 1'b1;
            else begin
                if (d[1]) last_clr = ce + 1;
                else if (hold_m) last_clr = ce;
                hold_m = 1'b0;
            end
        end
        if (!a[4] && a[3:2] == 2'd2) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) scratch_m[8*b +: 8] = d[8*b +: 8];
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the B handshake
    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly,
                             output logic [1:0] resp, output int commit_edge);
        int cyc = 0;
        int aw_edge = -1;
        int w_edge = -1;
        bit aw_done = 0, w_done = 0, b_done = 0, seen_bv = 0, bad = 0;
        logic [1:0] first_resp = '0;
        commit_edge = -1;
        resp = 2'bxx;
        while (!b_done && cyc < 100) begin
            s_axil_awaddr  = a;
            s_axil_wdata   = d;
            s_axil_wstrb   = s;
            s_axil_awvalid = !aw_done && cyc >= aw_dly;
            s_axil_wvalid  = !w_done && cyc >= w_dly;
            s_axil_bready  = cyc >= b_dly;
            if (s_axil_bvalid && !seen_bv) begin
                seen_bv = 1; commit_edge = ecnt; first_resp = s_axil_bresp;
            end else if (seen_bv && (!s_axil_bvalid || s_axil_bresp !== first_resp)) bad = 1;
            if (!seen_bv && ((aw_done && s_axil_awready) || (w_done && s_axil_wready))) bad = 1;
            if (s_axil_awvalid && s_axil_awready) begin aw_done = 1; aw_edge = ecnt + 1; end
            if (s_axil_wvalid && s_axil_wready) begin w_done = 1; w_edge = ecnt + 1; end
            if (s_axil_bvalid && s_axil_bready) begin b_done = 1; resp = s_axil_bresp; end
            @(posedge clk); #1;
            cyc++;
        end
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        s_axil_bready  = 1'b0;
        check_eq("wr_done", 32'(b_done), 32'd1);
        check_eq("wr_protocol", 32'(bad), 32'd0);
        check_eq("wr_commit_edge", commit_edge, (aw_edge > w_edge) ? aw_edge : w_edge);
        check_eq("wr_idle_after", {s_axil_bvalid, s_axil_awready, s_axil_wready}, 3'b011);
    endtask

    task automatic axi_read(input logic [4:0] a, input int ar_dly, input int r_dly,
                            output logic [31:0] data, output logic [1:0] resp, output int hs_edge);
        int cyc = 0;
        int rv_edge = -1;
        bit ar_done = 0, r_done = 0, seen_rv = 0, bad = 0;
        logic [31:0] first_d = '0;
        logic [1:0]  first_r = '0;
        hs_edge = -1;
        data = 'x;
        resp = 'x;
        while (!r_done && cyc < 100) begin
            s_axil_araddr  = a;
            s_axil_arvalid = !ar_done && cyc >= ar_dly;
            s_axil_rready  = cyc >= r_dly;
            if (s_axil_rvalid && !seen_rv) begin
                seen_rv = 1; rv_edge = ecnt; first_d = s_axil_rdata; first_r = s_axil_rresp;
            end else if (seen_rv && (!s_axil_rvalid || s_axil_rdata !== first_d || s_axil_rresp !== first_r)) bad = 1;
            if (s_axil_arvalid && s_axil_arready) begin ar_done = 1; hs_edge = ecnt + 1; end
            if (s_axil_rvalid && s_axil_rready) begin r_done = 1; data = s_axil_rdata; resp = s_axil_rresp; end
            @(posedge clk); #1;
            cyc++;
        end
        s_axil_arvalid = 1'b0;
        s_axil_rready  = 1'b0;
        check_eq("rd_done", 32'(r_done), 32'd1);
        check_eq("rd_protocol", 32'(bad), 32'd0);
        check_eq("rd_latency", rv_edge, hs_edge);
        check_eq("rd_idle_after", {s_axil_rvalid, s_axil_arready}, 2'b01);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int awd, input int wd, input int bd);
        logic [1:0] resp;
        int ce;
        axi_write(a, d, s, awd, wd, bd, resp, ce);
        check_eq("wr_resp", 32'(resp), 32'(exp_wr_resp(a)));
        model_commit(a, d, s, ce);
    endtask

    task automatic do_read(input logic [4:0] a, input int ard, input int rd);
        logic [31:0] data;
        logic [1:0]  resp;
        int hs;
        axi_read(a, ard, rd, data, resp, hs);
        check_eq($sformatf("rd_data@%02h", a), data, exp_rd_data(a, hs));
        check_eq($sformatf("rd_resp@%02h", a), 32'(resp), a[4] ? 32'd2 : 32'd0);
    endtask

    initial begin
        int ur0, b0;
        logic [31:0] pre_ctrl;

        // reset and ID
        repeat (4) @(posedge clk);
        #1;
        check_eq("rst_readies", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b000);
        check_eq("rst_valids", {s_axil_bvalid, s_axil_rvalid, user_reset}, 3'b000);
        check_eq("rst_data", {s_axil_rdata, s_axil_rresp, s_axil_bresp}, '0);
        areset = 1'b1;
        last_clr = ecnt;
        check_eq("release_readies_low", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b000);
        @(posedge clk); #1;
        check_eq("release_readies_high", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);
        do_read(5'h0C, 0, 0);
        check_eq("ur_quiet_after_reset", ur_cycles, 0);

        // PULSE
        repeat (10) @(posedge clk);
        #1;
        ur0 = ur_cycles;
        do_write(5'h00, 32'h2, 4'hF, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("pulse_rise_edge", ur_rise_edge, last_commit);
        check_eq("pulse_width", ur_cycles - ur0, 1);
        do_read(5'h04, 0, 0);
        do_read(5'h00, 0, 1);

        // HOLD
        do_write(5'h00, 32'h1, 4'h1, 0, 0, 1);
        check_eq("hold_rise_edge", ur_rise_edge, last_commit);
        for (int i = 0; i < 5; i++) do_read(5'h04, i % 2, i);
        do_read(5'h00, 0, 0);
        do_write(5'h00, 32'h0, 4'hF, 1, 0, 0);
        repeat (7) @(posedge clk);
        #1;
        do_read(5'h04, 0, 0);

        // channel ordering and B back-pressure
        b0 = b_rises;
        do_write(5'h08, 32'hDEAD_BEEF, 4'b0101, 3, 0, 8);
        check_eq("single_commit", b_rises - b0, 1);
        do_read(5'h08, 0, 2);

        // errors
        do_write(5'h04, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        do_read(5'h04, 0, 0);
        do_write(5'h0C, 32'h0, 4'hF, 0, 1, 0);
        do_write(5'h18, 32'h1, 4'hF, 0, 0, 0);
        do_read(5'h10, 0, 0);
        do_read(5'h00, 0, 0);

        // CTRL read coinciding with CTRL commit returns the old value
        pre_ctrl = {31'b0, hold_m};
        s_axil_awaddr = 5'h00; s_axil_wdata = 32'h1; s_axil_wstrb = 4'hF;
        s_axil_araddr = 5'h00;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_arvalid = 1'b1;
        @(posedge clk); #1;
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
        model_commit(5'h00, 32'h1, 4'hF, ecnt);
        check_eq("conc_valids", {s_axil_bvalid, s_axil_rvalid, user_reset}, 3'b111);
        check_eq("conc_rdata", s_axil_rdata, pre_ctrl);
        s_axil_bready = 1'b1; s_axil_rready = 1'b1;
        @(posedge clk); #1;
        s_axil_bready = 1'b0; s_axil_rready = 1'b0;
        do_write(5'h00, 32'h0, 4'h1, 0, 0, 0);

        // randomized traffic against the model
        for (int i = 0; i < 80; i++) begin
            logic [4:0] a;
            a = {($urandom_range(0, 4) == 0), 4'($urandom)};
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 5));
            else
                do_read(a, $urandom_range(0, 3), $urandom_range(0, 5));
        end

        // reset in the middle of a write response
        s_axil_awaddr = 5'h00; s_axil_wdata = 32'h1; s_axil_wstrb = 4'hF;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_bready = 1'b0;
        for (int k = 0; k < 4 && !(s_axil_awready && s_axil_wready); k++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        check_eq("mid_bvalid_before", 32'(s_axil_bvalid), 32'd1);
        #2;
        areset = 1'b0;
        #1;
        check_eq("mid_async_clear", {s_axil_bvalid, s_axil_rvalid, user_reset,
                                     s_axil_awready, s_axil_arready}, 5'b00000);
        repeat (2) @(posedge clk);
        #1;
        areset = 1'b1;
        last_clr = ecnt;
        hold_m = 1'b0;
        scratch_m = '0;
        @(posedge clk); #1;
        do_read(5'h00, 0, 0);
        do_read(5'h08, 0, 0);
        do_read(5'h04, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_axil_regs.md
# counter_axil_regs

AXI4-Lite register slave that sits directly upstream of the `Counter` block. It gives the PS software a control register that drives `Counter.user_reset`, and it exposes `Counter.dataout` as a read-only register. The block handles one outstanding read and one outstanding write, each with full valid/ready handshakes on all five channels.

## Interface
- `COUNTER_WIDTH`, default 4: width of `counter_datain`; valid range 1–32.
- `ADDR_WIDTH`, default 4: AXI address width; minimum 4.
- `clk` in 1: sole clock.
- `areset` in 1: asynchronous, active-low reset.
- `s_axil_awaddr` in ADDR_WIDTH, `s_axil_awvalid` in 1, `s_axil_awready` out 1: write-address channel.
- `s_axil_wdata` in 32, `s_axil_wstrb` in 4, `s_axil_wvalid` in 1, `s_axil_wready` out 1: write-data channel.
- `s_axil_bresp` out 2, `s_axil_bvalid` out 1, `s_axil_bready` in 1: write-response channel.
- `s_axil_araddr` in ADDR_WIDTH, `s_axil_arvalid` in 1, `s_axil_arready` out 1: read-address channel.
- `s_axil_rdata` out 32, `s_axil_rresp` out 2, `s_axil_rvalid` out 1, `s_axil_rready` in 1: read-data channel.
- `counter_datain` in COUNTER_WIDTH: connects to `Counter.dataout`.
- `user_reset` out 1: connects to `Counter.user_reset`; active-high.

## Operation
- **Register map.** Decode uses word offset `addr[3:2]`. Any address with `addr[ADDR_WIDTH-1:4] != 0` is unmapped.
  - 0x0 CTRL, RW:
    - bit0 HOLD: level; keeps the counter in reset while set.
    - bit1 PULSE: write-1 generates a one-cycle reset. It is not stored and reads as 0.
    - All other bits read as 0.
  - 0x4 COUNT, RO: `counter_datain`, zero-extended to 32 bits.
  - 0x8 SCRATCH, RW: full 32 bits, with per-byte `wstrb`.
  - 0xC ID, RO: `32'h434E_5400 | COUNTER_WIDTH`.
- **User reset.** `user_reset = HOLD | pulse_q`. `pulse_q` is a register that is high for exactly one cycle.
- **Write path.** The AW and W channels are accepted independently, in either order or in the same cycle.
  - Each ready is deasserted once its beat has been latched.
  - The commit happens on the edge where both beats are held. On that edge: the register updates, `pulse_q` is set if applicable, and `bvalid` rises.
  - `bvalid` holds until `bready` is seen. On the `bready` handshake, `awready` and `wready` return to 1.
- **CTRL strobes.** A CTRL write with `wstrb[0]=0` leaves CTRL unchanged, generates no pulse, and returns OKAY.
- **Response codes.**
  - OKAY (2'b00): writes to RW registers and all mapped reads.
  - SLVERR (2'b10): writes to COUNT or ID (no state change), and any unmapped read or write. Unmapped reads return `rdata = 0`.
- **Read path.** `arready=1` in the idle state.
  - On the AR handshake, `rdata` and `rresp` are registered. COUNT is sampled at that edge. `rvalid` rises on the same edge and `arready` drops.
  - On the `rready` handshake, `rvalid` drops and `arready` returns to 1.
- **Concurrency.** The read and write paths are independent and may complete in the same cycle.
  - A read of CTRL that coincides with a CTRL commit returns the pre-commit value.
- **State machines.**
  - Write FSM: W_IDLE (collecting AW/W) → W_RESP (`bvalid`) → W_IDLE.
  - Read FSM: R_IDLE → R_DATA → R_IDLE.

## Timing
- **Reset.** While `areset=0`, all outputs are 0: readies, valids, resp, `rdata`, `user_reset`. CTRL, SCRATCH and `pulse_q` are also 0.
  - The readies are driven to 1 from the first rising edge after `areset` is released.
- **Write latency.** With AW and W in the same cycle, `bvalid` is high on the next cycle, and `user_reset` is high in that same cycle as a result of PULSE or HOLD.
- **Read latency.** `rvalid` is high in the cycle after the AR handshake.
- **Back-pressure.** While `bvalid=1` with `bready=0`, no new AW or W is accepted. While `rvalid=1` with `rready=0`, no new AR is accepted.
- **Output stability.** `rdata`, `rresp` and `bresp` are stable while their valid is high.
- **Reset mid-transaction.** Asserting `areset` mid-transaction drops every valid immediately (asynchronously) and discards any pending beats.

## Structure
- **Package `counter_regs_pkg`:**
  - Address offsets `CTRL_OFS`, `COUNT_OFS`, `SCRATCH_OFS`, `ID_OFS`.
  - `ID_BASE = 32'h434E_5400`.
  - `RESP_OKAY`, `RESP_SLVERR`.
  - Write- and read-FSM state enums.
- **Hierarchy.** No sub-module is needed. Implement two FSM processes in a single module. Expected size is about 200 lines.

## Test plan
- **Reset and ID.** Hold `areset` low for 4 cycles, then release it; read 0x0C → `rdata = 32'h434E_5404`, OKAY; `user_reset` stays 0 throughout.
- **PULSE.** `Counter` has run for 10 cycles. Write 0x0 = 0x2 → `user_reset` is high for exactly 1 cycle; read 0x4 three cycles later → 2 (assuming `Counter` counts 1 per cycle and clears synchronously).
- **HOLD.** Write 0x0 = 0x1; read 0x4 five times → always 0. Then write 0x0 = 0x0; 7 cycles later read 0x4 → 7 ± read latency, checked against a model.
- **Channel ordering and back-pressure.** W leads AW by 3 cycles, with `bready` held low for 4 cycles → exactly one commit; `bvalid` stays high until `bready`; SCRATCH written as 0xDEADBEEF with `wstrb = 4'b0101` reads back as `0x00AD00EF`.
- **Errors.** Write to 0x4 → SLVERR and COUNT is unaffected. Read 0x10 with `ADDR_WIDTH = 5` → SLVERR, `rdata = 0`.
- **Reset mid-transaction.** Drop `areset` while `bvalid = 1` → `bvalid` goes to 0 asynchronously; after release, CTRL reads 0.
